// File: rtl/cuppa_trig_pkg.sv
// Shared types and constants for the CUPPA trigger generator.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: FSM state enum, trigger mode bit indices, mode-match helper.
package cuppa_trig_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    FIRE    = 2'd2,
    HOLDOFF = 2'd3
  } trig_state_t;

  // Bit positions inside the packed mode vector, same order as the
  // cuppa_trig configuration bundle.
  localparam int MODE_ET = 0;
  localparam int MODE_GT = 1;
  localparam int MODE_LT = 2;
  localparam int MODE_W  = 3;

  // Enabled compare modes are OR'd; an all-zero mode vector never matches.
  function automatic logic mode_match(input logic [MODE_W-1:0] mode,
                                      input logic is_gt,
                                      input logic is_lt,
                                      input logic is_eq);
    return (mode[MODE_GT] & is_gt) | (mode[MODE_LT] & is_lt) | (mode[MODE_ET] & is_eq);
  endfunction

endpackage

// File: rtl/cuppa_trig_chan_cmp.sv
// Per-channel threshold compare with crossing detection.
// Latency: hit asserts one cycle after the qualifying valid sample.
// Backpressure: none; every valid sample is consumed.
// Ports: clk/rst, sample + adc_valid, en (global & channel enable),
//        mode (ET/GT/LT), thresh (unsigned), hit (entry into condition).
module cuppa_trig_chan_cmp
  import cuppa_trig_pkg::*;
#(
  parameter int ADC_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADC_W-1:0]  sample,
  input  logic              adc_valid,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [ADC_W-1:0]  thresh,
  output logic              hit
);

  logic cond;
  logic cond_q;
  logic prev_q;
  logic upd_q;

  assign cond = en & mode_match(mode, sample > thresh, sample < thresh, sample == thresh);

  always_ff @(posedge clk) begin
    if (rst) begin
      cond_q <= 1'b0;
      prev_q <= 1'b0;
      upd_q  <= 1'b0;
    end else begin
      // upd_q marks that cond_q/prev_q just advanced, so a crossing is
      // reported once per valid sample and never on idle cycles.
      upd_q <= adc_valid;
      if (adc_valid) begin
        cond_q <= cond;
        prev_q <= cond_q;
      end
    end
  end

  assign hit = upd_q & cond_q & ~prev_q;

endmodule

// File: rtl/cuppa_trig_gen.sv
// Multi-channel threshold / external trigger generator with holdoff.
// Latency: valid sample at n -> trig_out at n+2 (armed at n+1); ext edge at m -> trig_out at m+1.
// Backpressure: none; hits seen outside ARMED are dropped.
// Ports: adc_data/adc_valid/chan_en samples, trig_* config, ext_trig_*,
//        arm strobe, holdoff; outputs trig_out pulse, trig_chan/trig_ext
//        source flags, armed, saturating trig_count.
module cuppa_trig_gen
  import cuppa_trig_pkg::*;
#(
  parameter int N_CHAN    = 2,
  parameter int ADC_W     = 12,
  parameter int HOLDOFF_W = 16,
  parameter int CNT_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CHAN*ADC_W-1:0] adc_data,
  input  logic                    adc_valid,
  input  logic [N_CHAN-1:0]       chan_en,
  input  logic                    trig_et,
  input  logic                    trig_gt,
  input  logic                    trig_lt,
  input  logic                    trig_run,
  input  logic [ADC_W-1:0]        trig_thresh,
  input  logic                    thresh_trig_en,
  input  logic                    ext_trig_en,
  input  logic                    ext_trig_in,
  input  logic                    arm,
  input  logic [HOLDOFF_W-1:0]    holdoff,
  output logic                    trig_out,
  output logic [N_CHAN-1:0]       trig_chan,
  output logic                    trig_ext,
  output logic                    armed,
  output logic [CNT_W-1:0]        trig_count
);

  logic [MODE_W-1:0]    mode;
  logic [N_CHAN-1:0]    hit;
  logic                 ext_q;
  logic                 ext_hit;
  logic                 any_hit;
  trig_state_t          state;
  trig_state_t          state_nxt;
  trig_state_t          rearm_state;
  logic [HOLDOFF_W-1:0] hold_cnt;
  logic [N_CHAN-1:0]    chan_lat;
  logic                 ext_lat;

  always_comb begin
    mode          = '0;
    mode[MODE_ET] = trig_et;
    mode[MODE_GT] = trig_gt;
    mode[MODE_LT] = trig_lt;
  end

  for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
    cuppa_trig_chan_cmp #(
      .ADC_W(ADC_W)
    ) u_cmp (
      .clk       (clk),
      .rst       (rst),
      .sample    (adc_data[c*ADC_W +: ADC_W]),
      .adc_valid (adc_valid),
      .en        (thresh_trig_en & chan_en[c]),
      .mode      (mode),
      .thresh    (trig_thresh),
      .hit       (hit[c])
    );
  end

  // Edge tracking runs in every state so a level held through holdoff
  // cannot produce a late trigger when the block re-arms.
  assign ext_hit = ext_trig_en & ext_trig_in & ~ext_q;
  assign any_hit = (|hit) | ext_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ext_q      <= 1'b0;
      hold_cnt   <= '0;
      chan_lat   <= '0;
      ext_lat    <= 1'b0;
      trig_count <= '0;
    end else begin
      state <= state_nxt;
      ext_q <= ext_trig_in;
      if (state == ARMED && any_hit) begin
        chan_lat <= hit;
        ext_lat  <= ext_hit;
      end
      if (state == FIRE) begin
        hold_cnt <= holdoff;
        if (trig_count != '1) trig_count <= trig_count + CNT_W'(1);
      end else if (state == HOLDOFF) begin
        hold_cnt <= hold_cnt - HOLDOFF_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    rearm_state = trig_run ? ARMED : IDLE;
    trig_out    = 1'b0;
    trig_chan   = '0;
    trig_ext    = 1'b0;
    armed       = 1'b0;
    case (state)
      IDLE: begin
        if (trig_run || arm) state_nxt = ARMED;
      end
      ARMED: begin
        armed = 1'b1;
        if (any_hit) state_nxt = FIRE;
      end
      FIRE: begin
        trig_out  = 1'b1;
        trig_chan = chan_lat;
        trig_ext  = ext_lat;
        state_nxt = (holdoff == '0) ? rearm_state : HOLDOFF;
      end
      HOLDOFF: begin
        // Counter starts at holdoff in the first HOLDOFF cycle, so leaving
        // when it shows 1 yields exactly holdoff dead cycles.
        if (hold_cnt <= HOLDOFF_W'(1)) state_nxt = rearm_state;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cuppa_trig_gen.sv
module tb_cuppa_trig_gen;

  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [11:0]     s0, s1;
  logic [23:0]     adc_data;
  logic            adc_valid;
  logic [1:0]      chan_en;
  logic            trig_et, trig_gt, trig_lt, trig_run;
  logic [11:0]     trig_thresh;
  logic            thresh_trig_en, ext_trig_en, ext_trig_in, arm;
  logic [15:0]     holdoff;
  logic            trig_out;
  logic [1:0]      trig_chan;
  logic            trig_ext;
  logic            armed;
  logic [CW-1:0]   trig_count;

  assign adc_data = {s1, s0};

  always #5 clk = ~clk;

  cuppa_trig_gen #(.N_CHAN(2), .ADC_W(12), .HOLDOFF_W(16), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid),
    .chan_en(chan_en), .trig_et(trig_et), .trig_gt(trig_gt), .trig_lt(trig_lt),
    .trig_run(trig_run), .trig_thresh(trig_thresh), .thresh_trig_en(thresh_trig_en),
    .ext_trig_en(ext_trig_en), .ext_trig_in(ext_trig_in), .arm(arm), .holdoff(holdoff),
    .trig_out(trig_out), .trig_chan(trig_chan), .trig_ext(trig_ext), .armed(armed),
    .trig_count(trig_count)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // sampled DUT outputs of the most recent cycle
  logic          o_out, o_ext, o_armed;
  logic [1:0]    o_chan;
  logic [CW-1:0] o_cnt;

  // Reference model: timestamp-based view of the trigger life cycle.
  bit            m_live, m_fire, m_wait;
  int            m_rearm;
  bit [1:0]      m_fchan;
  bit            m_fext;
  int            m_cnt;
  bit [1:0]      m_last, m_prev;
  bit            m_vprev, m_extprev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit ref_cond(input int c, input logic [11:0] s);
    int v, t;
    v = int'(s);
    t = int'(trig_thresh);
    return thresh_trig_en && chan_en[c] &&
           ((trig_gt && v > t) || (trig_lt && v < t) || (trig_et && v == t));
  endfunction

  task automatic model_step();
    bit [1:0] h;
    bit eh;
    if (rst) begin
      m_live = 0; m_fire = 0; m_wait = 0; m_rearm = 0; m_fchan = 0; m_fext = 0;
      m_cnt = 0; m_last = 0; m_prev = 0; m_vprev = 0; m_extprev = 0;
      return;
    end
    for (int c = 0; c < 2; c++) h[c] = m_vprev && m_last[c] && !m_prev[c];
    eh = ext_trig_en && ext_trig_in && !m_extprev;
    if (m_fire) begin
      m_fire = 0;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
      if (holdoff == 0) m_live = trig_run;
      else begin m_wait = 1; m_rearm = cyc + int'(holdoff) + 1; end
    end else if (m_live) begin
      if (h != 0 || eh) begin m_fire = 1; m_live = 0; m_fchan = h; m_fext = eh; end
    end else if (m_wait) begin
      if (cyc + 1 == m_rearm) begin m_wait = 0; m_live = trig_run; end
    end else begin
      if (trig_run || arm) m_live = 1;
    end
    if (adc_valid) begin
      m_prev = m_last;
      m_last[0] = ref_cond(0, s0);
      m_last[1] = ref_cond(1, s1);
    end
    m_vprev   = adc_valid;
    m_extprev = ext_trig_in;
  endtask

  // One clock cycle: inputs are already driven; sample mid-cycle, compare
  // against the model, advance the model, then move past the next edge.
  task automatic tick(input bit chk);
    logic [63:0] exp;
    @(negedge clk);
    o_out = trig_out; o_chan = trig_chan; o_ext = trig_ext; o_armed = armed; o_cnt = trig_count;
    if (chk) begin
      exp = {55'd0, m_fire, (m_fire ? m_fchan : 2'b00), (m_fire & m_fext), m_live, CW'(m_cnt)};
      check("model", {55'd0, o_out, o_chan, o_ext, o_armed, o_cnt}, exp);
    end
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_cfg(input bit et, gt, lt, run, input logic [11:0] thr,
                         input bit ten, een, input logic [1:0] cen, input logic [15:0] hold);
    trig_et = et; trig_gt = gt; trig_lt = lt; trig_run = run; trig_thresh = thr;
    thresh_trig_en = ten; ext_trig_en = een; chan_en = cen; holdoff = hold;
  endtask

  task automatic do_reset();
    rst = 1; adc_valid = 0; ext_trig_in = 0; arm = 0;
    tick(1);
    rst = 0;
  endtask

  typedef struct {
    logic [11:0] s0, s1;
    bit          vld, ext;
    bit          e_out;
    logic [1:0]  e_chan;
    bit          e_ext, e_armed;
  } vec_t;

  vec_t vt[11];

  task automatic run_vec(input int i);
    s0 = vt[i].s0; s1 = vt[i].s1; adc_valid = vt[i].vld; ext_trig_in = vt[i].ext;
    tick(1);
    check($sformatf("vec%0d", i), {60'd0, o_out, o_chan, o_armed},
          {60'd0, vt[i].e_out, vt[i].e_chan, vt[i].e_armed});
    check($sformatf("vec%0d_ext", i), {63'd0, o_ext}, {63'd0, vt[i].e_ext});
  endtask

  initial begin
    int pulses, fcyc, acyc;
    logic [1:0] pch;
    bit pex;

    // gt crossing on ch0: fire two cycles after 0x801, nothing on 0x900
    vt[0]  = '{12'h700, 12'h000, 1, 0, 0, 2'b00, 0, 0};
    vt[1]  = '{12'h801, 12'h000, 1, 0, 0, 2'b00, 0, 1};
    vt[2]  = '{12'h900, 12'h000, 1, 0, 0, 2'b00, 0, 1};
    vt[3]  = '{12'h900, 12'h000, 1, 0, 1, 2'b01, 0, 0};
    vt[4]  = '{12'h900, 12'h000, 1, 0, 0, 2'b00, 0, 1};
    vt[5]  = '{12'h900, 12'h000, 0, 0, 0, 2'b00, 0, 1};
    // et on both channels together with an ext edge
    vt[6]  = '{12'h100, 12'h100, 1, 0, 0, 2'b00, 0, 0};
    vt[7]  = '{12'h123, 12'h123, 1, 0, 0, 2'b00, 0, 1};
    vt[8]  = '{12'h123, 12'h123, 1, 1, 0, 2'b00, 0, 1};
    vt[9]  = '{12'h100, 12'h100, 1, 1, 1, 2'b11, 1, 0};
    vt[10] = '{12'h100, 12'h100, 0, 0, 0, 2'b00, 0, 1};

    s0 = 0; s1 = 0; rst = 1; adc_valid = 0; ext_trig_in = 0; arm = 0;
    set_cfg(0, 1, 0, 1, 12'h800, 1, 0, 2'b11, 16'd0);
    tick(0);
    tick(0);
    rst = 0;
    tick(1);
    check("reset_out", {59'd0, o_out, o_chan, o_ext, o_armed}, 64'd0);
    check("reset_cnt", {60'd0, o_cnt}, 64'd0);

    // Table 1: gt mode
    set_cfg(0, 1, 0, 1, 12'h800, 1, 0, 2'b11, 16'd0);
    do_reset();
    for (int i = 0; i < 6; i++) run_vec(i);
    check("gt_count", {60'd0, o_cnt}, 64'd1);

    // Table 2: et mode, simultaneous channel + ext hits
    set_cfg(1, 0, 0, 1, 12'h123, 1, 1, 2'b11, 16'd0);
    do_reset();
    for (int i = 6; i < 11; i++) run_vec(i);

    // lt single-shot: no trigger without arm, one trigger after arm
    set_cfg(0, 0, 1, 0, 12'h800, 1, 0, 2'b11, 16'd0);
    do_reset();
    pulses = 0; acyc = 0;
    s0 = 12'h900;
    for (int k = 0; k < 8; k++) begin
      adc_valid = (k < 2);
      s1 = (k == 0) ? 12'h900 : 12'h100;
      tick(1);
      if (o_out) pulses++;
      if (o_armed) acyc++;
    end
    check("lt_noarm_pulses", 64'(pulses), 64'd0);
    check("lt_noarm_armed", 64'(acyc), 64'd0);
    arm = 1; adc_valid = 0;
    tick(1);
    arm = 0;
    pulses = 0; pch = 0;
    for (int k = 0; k < 8; k++) begin
      adc_valid = (k < 2);
      s1 = (k == 0) ? 12'h900 : 12'h100;
      tick(1);
      if (o_out) begin pulses++; pch = o_chan; end
    end
    check("lt_arm_pulses", 64'(pulses), 64'd1);
    check("lt_arm_chan", {62'd0, pch}, 64'd2);
    check("lt_idle_after", {63'd0, o_armed}, 64'd0);

    // ext trigger with holdoff 5; second edge inside holdoff ignored
    set_cfg(0, 0, 0, 1, 12'h800, 0, 1, 2'b11, 16'd5);
    do_reset();
    pulses = 0; fcyc = -1; acyc = -1; pch = 0; pex = 0;
    for (int k = 0; k < 14; k++) begin
      ext_trig_in = (k == 2 || k == 5 || k == 6);
      tick(1);
      if (o_out) begin pulses++; fcyc = k; pch = o_chan; pex = o_ext; end
      if (o_armed && fcyc >= 0 && acyc < 0) acyc = k;
    end
    check("ext_pulses", 64'(pulses), 64'd1);
    check("ext_flag", {63'd0, pex}, 64'd1);
    check("ext_chan", {62'd0, pch}, 64'd0);
    check("ext_rearm_gap", 64'(acyc - fcyc - 1), 64'd5);

    // channel disabled, then data toggling without adc_valid
    set_cfg(0, 1, 0, 1, 12'h800, 1, 0, 2'b10, 16'd0);
    do_reset();
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      adc_valid = (k < 8);
      s0 = k[0] ? 12'h900 : 12'h100;
      s1 = (k < 8) ? 12'h100 : (k[0] ? 12'h900 : 12'h100);
      tick(1);
      if (o_out) pulses++;
    end
    check("chan_dis_pulses", 64'(pulses), 64'd0);

    // reset during a long holdoff
    set_cfg(0, 0, 0, 1, 12'h800, 0, 1, 2'b11, 16'd100);
    do_reset();
    for (int k = 0; k < 13; k++) begin
      ext_trig_in = (k == 2);
      tick(1);
    end
    check("hold_mid_armed", {63'd0, o_armed}, 64'd0);
    check("hold_mid_cnt", {60'd0, o_cnt}, 64'd1);
    rst = 1;
    tick(1);
    rst = 0;
    tick(1);
    check("rst_hold_out", {59'd0, o_out, o_chan, o_ext, o_armed}, 64'd0);
    check("rst_hold_cnt", {60'd0, o_cnt}, 64'd0);

    // counter saturation
    set_cfg(0, 0, 0, 1, 12'h800, 0, 1, 2'b11, 16'd0);
    do_reset();
    pulses = 0;
    for (int k = 0; k < 44; k++) begin
      ext_trig_in = ~k[0];
      tick(1);
      if (o_out) pulses++;
    end
    check("sat_pulses", {63'd0, pulses > 16}, 64'd1);
    check("sat_count", {60'd0, o_cnt}, 64'd15);

    // randomized segments against the model
    for (int seg = 0; seg < 8; seg++) begin
      set_cfg($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), 12'($urandom_range(12'h7f0, 12'h810)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 1),
              2'($urandom_range(0, 3)), 16'($urandom_range(0, 6)));
      do_reset();
      for (int k = 0; k < 200; k++) begin
        s0 = 12'(int'(trig_thresh) + int'($urandom_range(0, 8)) - 4);
        s1 = 12'(int'(trig_thresh) + int'($urandom_range(0, 8)) - 4);
        adc_valid   = $urandom_range(0, 3) != 0;
        ext_trig_in = $urandom_range(0, 2) == 0;
        arm         = $urandom_range(0, 9) == 0;
        rst         = $urandom_range(0, 149) == 0;
        tick(1);
      end
      rst = 0; arm = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
